// File: rtl/fmap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fmap_pkg
//  Description : Shared defaults, FSM encoding and FIFO sizing for the
//                feature-map stream reader.
//  Revision    : 1.0  initial release
// ============================================================================
package fmap_pkg;

   localparam int FMAP_DATA_WIDTH = 16;
   localparam int FMAP_ADDR_WIDTH = 10;

   // Skid FIFO holds at most two words; the count needs to represent 0..2.
   localparam int FIFO_DEPTH      = 2;
   localparam int FIFO_CNT_W      = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fmap_state_t;

endpackage
`default_nettype wire

// File: rtl/fmap_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fmap_skid_fifo
//  Description : Two-entry first-word-fall-through FIFO absorbing RAM read
//                latency. Callers never push when full or pop when empty.
//  Revision    : 1.0  initial release
// ============================================================================
module fmap_skid_fifo
   import fmap_pkg::*;
#(
   parameter int DATA_WIDTH = FMAP_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [FIFO_CNT_W-1:0] count
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic                  wr_ptr;
   logic                  rd_ptr;

   // Storage, pointers and occupancy; simultaneous push and pop keep the count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + FIFO_CNT_W'(1);
            2'b01:   count <= count - FIFO_CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fmap_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fmap_stream_reader
//  Description : Drains a finished feature map from RAM port B in address
//                order and hands it to the next layer over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module fmap_stream_reader
   import fmap_pkg::*;
#(
   parameter int DATA_WIDTH      = FMAP_DATA_WIDTH,
   parameter int POOL_ADDR_WIDTH = FMAP_ADDR_WIDTH,
   parameter int FMAP_WORDS      = 784,
   parameter int RAM_LATENCY     = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [DATA_WIDTH-1:0]      ram_q,
   output logic                       ram_rden_b,
   output logic                       ram_wren_b,
   output logic [POOL_ADDR_WIDTH-1:0] ram_address_b,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       done
);

   // One extra bit so a map filling the whole RAM does not wrap the counters.
   localparam int             CW        = POOL_ADDR_WIDTH + 1;
   localparam logic [CW-1:0]  LAST_ADDR = CW'(FMAP_WORDS - 1);
   localparam logic [CW-1:0]  TOTAL     = CW'(FMAP_WORDS);

   fmap_state_t               state;
   logic [CW-1:0]             rd_addr;
   logic [CW-1:0]             sent_cnt;
   logic [RAM_LATENCY-1:0]    issue_sr;
   logic [2:0]                inflight;
   logic [2:0]                occupancy;
   logic [FIFO_CNT_W-1:0]     fifo_count;
   logic                      push;
   logic                      pop;
   logic                      issue;

   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid & out_ready;
   assign push      = issue_sr[RAM_LATENCY-1];

   // Count reads still travelling through the RAM pipeline.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
         inflight = inflight + {2'b00, issue_sr[i]};
      end
   end

   // A new read is allowed only if its word is guaranteed a FIFO slot on arrival.
   assign occupancy     = {1'b0, fifo_count} + inflight - {2'b00, pop};
   assign issue         = (state == ST_READ) && (occupancy < 3'd2);
   assign ram_rden_b    = issue;
   assign ram_wren_b    = 1'b0;
   assign ram_address_b = rd_addr[POOL_ADDR_WIDTH-1:0];

   generate
      if (RAM_LATENCY == 1) begin : g_lat1
         // Single-stage issue tracker: flag lines up with ram_q one cycle later.
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) issue_sr <= '0;
            else        issue_sr <= issue;
         end
      end else begin : g_latn
         // Multi-stage issue tracker matching the RAM pipeline depth.
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) issue_sr <= '0;
            else        issue_sr <= {issue_sr[RAM_LATENCY-2:0], issue};
         end
      end
   endgenerate

   fmap_skid_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (ram_q),
      .pop       (pop),
      .head_data (out_data),
      .count     (fifo_count)
   );

   // Control FSM with address/pop counters and registered busy/done.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         rd_addr  <= '0;
         sent_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (issue) rd_addr  <= rd_addr + CW'(1);
         if (pop)   sent_cnt <= sent_cnt + CW'(1);
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state    <= ST_READ;
                  rd_addr  <= '0;
                  sent_cnt <= '0;
                  busy     <= 1'b1;
               end
            end
            ST_READ: begin
               if (issue && (rd_addr == LAST_ADDR)) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (pop && ((sent_cnt + CW'(1)) == TOTAL)) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fmap_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fmap_stream_reader
//  Description : Directed self-checking bench for fmap_stream_reader using
//                three instances (4 words, 784 words, 1 word with latency 2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fmap_stream_reader;

   localparam int DW = 16;
   localparam int AW = 10;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic          start_a, start_b, start_c;
   logic          rdy_a, rdy_b, rdy_c;
   logic [DW-1:0] q_a, q_b, q_c, c_stage;
   logic [DW-1:0] d_a, d_b, d_c;
   logic          rden_a, rden_b, rden_c, wren_a, wren_b, wren_c;
   logic          valid_a, valid_b, valid_c;
   logic          busy_a, busy_b, busy_c, done_a, done_b, done_c;
   logic [AW-1:0] addr_a, addr_b, addr_c;
   logic [DW-1:0] mem_a [1024];
   logic [DW-1:0] mem_b [1024];
   logic [DW-1:0] mem_c [1024];

   int            sel = 0;
   logic          start_x = 1'b0;
   logic          ready_x = 1'b0;
   logic          mon_rden, mon_wren, mon_valid, mon_busy, mon_done;
   logic [AW-1:0] mon_addr;
   logic [DW-1:0] mon_data;

   assign start_a = start_x && (sel == 0);
   assign start_b = start_x && (sel == 1);
   assign start_c = start_x && (sel == 2);
   assign rdy_a   = ready_x && (sel == 0);
   assign rdy_b   = ready_x && (sel == 1);
   assign rdy_c   = ready_x && (sel == 2);

   fmap_stream_reader #(.DATA_WIDTH(DW), .POOL_ADDR_WIDTH(AW), .FMAP_WORDS(4), .RAM_LATENCY(1)) dut_a (
      .clock(clock), .reset(reset), .start(start_a), .ram_q(q_a), .ram_rden_b(rden_a),
      .ram_wren_b(wren_a), .ram_address_b(addr_a), .out_data(d_a), .out_valid(valid_a),
      .out_ready(rdy_a), .busy(busy_a), .done(done_a));

   fmap_stream_reader #(.DATA_WIDTH(DW), .POOL_ADDR_WIDTH(AW), .FMAP_WORDS(784), .RAM_LATENCY(1)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .ram_q(q_b), .ram_rden_b(rden_b),
      .ram_wren_b(wren_b), .ram_address_b(addr_b), .out_data(d_b), .out_valid(valid_b),
      .out_ready(rdy_b), .busy(busy_b), .done(done_b));

   fmap_stream_reader #(.DATA_WIDTH(DW), .POOL_ADDR_WIDTH(AW), .FMAP_WORDS(1), .RAM_LATENCY(2)) dut_c (
      .clock(clock), .reset(reset), .start(start_c), .ram_q(q_c), .ram_rden_b(rden_c),
      .ram_wren_b(wren_c), .ram_address_b(addr_c), .out_data(d_c), .out_valid(valid_c),
      .out_ready(rdy_c), .busy(busy_c), .done(done_c));

   // RAM models: latency 1 for a/b, latency 2 for c.
   always @(posedge clock) begin
      if (rden_a) q_a <= mem_a[addr_a];
      if (rden_b) q_b <= mem_b[addr_b];
      if (rden_c) c_stage <= mem_c[addr_c];
      q_c <= c_stage;
   end

   // Observe whichever instance is under test.
   always_comb begin
      mon_rden = rden_a; mon_wren = wren_a; mon_addr = addr_a; mon_valid = valid_a;
      mon_data = d_a;    mon_busy = busy_a; mon_done = done_a;
      if (sel == 1) begin
         mon_rden = rden_b; mon_wren = wren_b; mon_addr = addr_b; mon_valid = valid_b;
         mon_data = d_b;    mon_busy = busy_b; mon_done = done_b;
      end else if (sel == 2) begin
         mon_rden = rden_c; mon_wren = wren_c; mon_addr = addr_c; mon_valid = valid_c;
         mon_data = d_c;    mon_busy = busy_c; mon_done = done_c;
      end
   end

   function automatic logic [DW-1:0] exp_word(input int s, input int i);
      case (s)
         0:       return DW'(32'h0011 * (i + 1));
         1:       return DW'(i * 40503 + 5);
         default: return 16'hBEEF;
      endcase
   endfunction

   int issue_cyc[$];
   int issue_addr[$];
   int pop_cyc[$];
   int pop_data[$];
   int done_cyc[$];
   int first_valid, busy_k1, wren_hi, hold_bad, hold_issue;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: ready held 1; mode 1: ready toggles 1,0,...; mode 2: ready low k=3..7
   task automatic run(input int mode, input int budget, input int restart_k);
      int stop_k;
      stop_k = -1;
      issue_cyc.delete(); issue_addr.delete(); pop_cyc.delete(); pop_data.delete(); done_cyc.delete();
      first_valid = -1; busy_k1 = 0; wren_hi = 0; hold_bad = 0; hold_issue = 0;
      @(negedge clock);
      start_x = 1'b1;
      ready_x = 1'b1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clock);
         start_x = (k == restart_k);
         case (mode)
            1:       ready_x = ((k % 2) == 1);
            2:       ready_x = !(k >= 3 && k <= 7);
            default: ready_x = 1'b1;
         endcase
         #1;
         if (mon_rden) begin issue_cyc.push_back(k); issue_addr.push_back(int'(mon_addr)); end
         if (mon_valid && first_valid < 0) first_valid = k;
         if (mon_valid && ready_x) begin pop_cyc.push_back(k); pop_data.push_back(int'(mon_data)); end
         if (mon_done) begin done_cyc.push_back(k); if (stop_k < 0) stop_k = k + 2; end
         if (k == 1) busy_k1 = int'(mon_busy);
         if (mon_wren) wren_hi++;
         if (mode == 2 && k >= 3 && k <= 7) begin
            if (!(mon_valid && mon_data == 16'h0011)) hold_bad++;
            if (mon_rden) hold_issue++;
         end
         if (k == stop_k) break;
      end
      start_x = 1'b0;
      ready_x = 1'b0;
   endtask

   task automatic check_stream(input string tag, input int n);
      int bad_a, bad_d, last_pop, d0;
      bad_a = 0; bad_d = 0;
      check({tag, "_issue_count"}, issue_addr.size(), n);
      check({tag, "_pop_count"}, pop_data.size(), n);
      for (int i = 0; i < issue_addr.size(); i++) if (issue_addr[i] != i) bad_a++;
      for (int i = 0; i < pop_data.size(); i++) if (pop_data[i] != int'(exp_word(sel, i))) bad_d++;
      check({tag, "_addr_order_bad"}, bad_a, 0);
      check({tag, "_data_order_bad"}, bad_d, 0);
      check({tag, "_done_pulses"}, done_cyc.size(), 1);
      last_pop = (pop_cyc.size() > 0) ? pop_cyc[pop_cyc.size() - 1] : -100;
      d0       = (done_cyc.size() > 0) ? done_cyc[0] : -1;
      check({tag, "_done_after_last_pop"}, d0, last_pop + 1);
      check({tag, "_wren_high"}, wren_hi, 0);
      check({tag, "_busy_k1"}, busy_k1, 1);
      check({tag, "_busy_end"}, {31'd0, mon_busy}, 0);
   endtask

   initial begin
      int bad, early;
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = exp_word(0, i);
         mem_b[i] = exp_word(1, i);
         mem_c[i] = exp_word(2, i);
      end

      // Reset state
      repeat (3) @(negedge clock);
      #1;
      check("rst_rden", {31'd0, mon_rden}, 0);
      check("rst_wren", {31'd0, mon_wren}, 0);
      check("rst_addr", {22'd0, mon_addr}, 0);
      check("rst_valid", {31'd0, mon_valid}, 0);
      check("rst_data", {16'd0, mon_data}, 0);
      check("rst_busy", {31'd0, mon_busy}, 0);
      check("rst_done", {31'd0, mon_done}, 0);
      check("rst_busy_b", {31'd0, busy_b}, 0);
      check("rst_valid_c", {31'd0, valid_c}, 0);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Basic 4-word drain with ready held high
      sel = 0;
      run(0, 30, -1);
      check_stream("t1", 4);
      check("t1_first_valid", first_valid, 3);
      bad = 0;
      for (int i = 0; i < issue_cyc.size(); i++) if (issue_cyc[i] != i + 1) bad++;
      check("t1_issue_cycles_bad", bad, 0);
      bad = 0;
      for (int i = 0; i < pop_cyc.size(); i++) if (pop_cyc[i] != i + 3) bad++;
      check("t1_pop_cycles_bad", bad, 0);
      check("t1_done_cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, 7);

      // Backpressure right after the first word appears
      repeat (2) @(negedge clock);
      run(2, 40, -1);
      check("t2_hold_bad", hold_bad, 0);
      check("t2_hold_issue", hold_issue, 0);
      early = 0;
      for (int i = 0; i < issue_cyc.size(); i++) if (issue_cyc[i] < 3) early++;
      check("t2_issues_before_stall", early, 2);
      check_stream("t2", 4);

      // Full 784-word map with ready toggling
      repeat (2) @(negedge clock);
      sel = 1;
      run(1, 2000, -1);
      check_stream("t3", 784);

      // Second start while draining is ignored
      repeat (2) @(negedge clock);
      sel = 0;
      run(0, 30, 5);
      check_stream("t4", 4);

      // Asynchronous reset in the middle of the read phase
      repeat (2) @(negedge clock);
      run(0, 4, -1);
      check("t5_pre_reset_addr", (issue_addr.size() == 4) ? issue_addr[3] : -1, 3);
      reset = 1'b0;
      #1;
      check("t5_rst_rden", {31'd0, mon_rden}, 0);
      check("t5_rst_addr", {22'd0, mon_addr}, 0);
      check("t5_rst_valid", {31'd0, mon_valid}, 0);
      check("t5_rst_data", {16'd0, mon_data}, 0);
      check("t5_rst_busy", {31'd0, mon_busy}, 0);
      check("t5_rst_done", {31'd0, mon_done}, 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      early = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         #1;
         if (mon_done || mon_busy || mon_valid) early++;
      end
      check("t5_quiet_after_reset", early, 0);
      run(0, 30, -1);
      check_stream("t5", 4);

      // Latency-2 RAM, single-word map
      repeat (2) @(negedge clock);
      sel = 2;
      run(0, 20, -1);
      check_stream("t6", 1);
      check("t6_first_valid", first_valid, 4);
      check("t6_data", (pop_data.size() > 0) ? pop_data[0] : -1, 32'hBEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
